// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard_pkg                                        |
// | Description : Shared defaults, descriptor field offsets and stage-entry    |
// |               layout helpers for the Tuse/Tnew hazard scoreboard.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hazard_scoreboard_pkg;

    localparam int DEF_NSTAGE = 3;
    localparam int DEF_NSRC   = 2;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_T_W    = 2;
    localparam int DEF_CNT_W  = 32;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_REGFILE = 0;

    // t_new sits at the bottom of a flattened stage entry.
    localparam int ENT_TNEW_LSB = 0;

    // LSB of source idx inside a packed per-source bus of field width fw.
    function automatic int src_lsb(input int idx, input int fw);
        return idx * fw;
    endfunction

    // Flattened stage entry layout: {valid, r_new, t_new}.
    function automatic int ent_w(input int reg_aw, input int t_w);
        return 1 + reg_aw + t_w;
    endfunction

    function automatic int ent_rnew_lsb(input int t_w);
        return t_w;
    endfunction

    function automatic int ent_valid_bit(input int reg_aw, input int t_w);
        return reg_aw + t_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard_if                                         |
// | Description : Decode-stage descriptor inputs and hazard outputs bundle.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int NSRC   = DEF_NSRC,
    parameter int REG_AW = DEF_REG_AW,
    parameter int T_W    = DEF_T_W,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int SEL_W = $clog2(NSTAGE + 1);

    logic                    d_valid;
    logic [REG_AW-1:0]       d_r_new;
    logic [T_W-1:0]          d_t_new;
    logic [NSRC*REG_AW-1:0]  d_r_use;
    logic [NSRC*T_W-1:0]     d_t_use;
    logic                    flush;
    logic                    stall;
    logic [NSRC-1:0]         stall_src;
    logic [NSRC*SEL_W-1:0]   fwd_sel;
    logic [CNT_W-1:0]        stall_cnt;

    // Pipeline control side: presents the D-stage descriptor, consumes hazards.
    modport master (
        output d_valid, d_r_new, d_t_new, d_r_use, d_t_use, flush,
        input  stall, stall_src, fwd_sel, stall_cnt
    );

    // Scoreboard side.
    modport slave (
        input  d_valid, d_r_new, d_t_new, d_r_use, d_t_use, flush,
        output stall, stall_src, fwd_sel, stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_match                                                 |
// | Description : Per-source hazard check: finds the youngest in-flight writer |
// |               of r_use and derives the stall cause and forwarding select.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int REG_AW = DEF_REG_AW,
    parameter int T_W    = DEF_T_W
) (
    input  wire logic [REG_AW-1:0]                  r_use,
    input  wire logic [T_W-1:0]                     t_use,
    input  wire logic [NSTAGE*(1+REG_AW+T_W)-1:0]   stage_vec,
    output logic                                    stall_src,
    output logic [$clog2(NSTAGE+1)-1:0]             fwd_sel
);
    localparam int SEL_W = $clog2(NSTAGE + 1);
    localparam int ENT_W = ent_w(REG_AW, T_W);
    localparam int V_BIT = ent_valid_bit(REG_AW, T_W);
    localparam int R_LSB = ent_rnew_lsb(T_W);

    logic             hit;
    logic [T_W-1:0]   hit_t_new;
    logic [SEL_W-1:0] hit_stage;

    // Scan oldest to youngest so the youngest matching writer is the last one kept.
    always_comb begin
        hit       = 1'b0;
        hit_t_new = '0;
        hit_stage = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (stage_vec[k*ENT_W + V_BIT] &&
                (stage_vec[k*ENT_W + R_LSB +: REG_AW] == r_use)) begin
                hit       = 1'b1;
                hit_t_new = stage_vec[k*ENT_W + ENT_TNEW_LSB +: T_W];
                hit_stage = SEL_W'(k + 1);
            end
        end
        // Register 0 is hardwired zero and never carries a dependency.
        if (r_use == '0) begin
            hit = 1'b0;
        end
        stall_src = hit && (hit_t_new > t_use);
        fwd_sel   = (hit && (hit_t_new == '0)) ? hit_stage : SEL_W'(FWD_REGFILE);
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard                                            |
// | Description : Tuse/Tnew hazard unit. Tracks in-flight writers through      |
// |               NSTAGE post-decode stages, drives D-stage stall, per-source  |
// |               forwarding selects and a saturating stall-cycle counter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int NSRC   = DEF_NSRC,
    parameter int REG_AW = DEF_REG_AW,
    parameter int T_W    = DEF_T_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic           clk,
    input  wire logic           reset,
    hazard_scoreboard_if.slave  bus
);
    localparam int SEL_W = $clog2(NSTAGE + 1);
    localparam int ENT_W = ent_w(REG_AW, T_W);

    // Index 0 is stage 1 (E); index NSTAGE-1 is the last write stage.
    logic [NSTAGE-1:0]             stg_valid_q, stg_valid_d;
    logic [NSTAGE-1:0][REG_AW-1:0] stg_rnew_q,  stg_rnew_d;
    logic [NSTAGE-1:0][T_W-1:0]    stg_tnew_q,  stg_tnew_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

    logic [NSTAGE*ENT_W-1:0]       stage_vec;
    logic [NSRC-1:0]               stall_src;
    logic [NSRC*SEL_W-1:0]         fwd_sel;
    logic                          stall;
    logic                          load;

    // One cycle closer to result availability, floored at zero.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_flat
            assign stage_vec[k*ENT_W +: ENT_W] = {stg_valid_q[k], stg_rnew_q[k], stg_tnew_q[k]};
        end

        for (genvar i = 0; i < NSRC; i++) begin : g_src
            hazard_match #(
                .NSTAGE (NSTAGE),
                .REG_AW (REG_AW),
                .T_W    (T_W)
            ) u_match (
                .r_use     (bus.d_r_use[src_lsb(i, REG_AW) +: REG_AW]),
                .t_use     (bus.d_t_use[src_lsb(i, T_W) +: T_W]),
                .stage_vec (stage_vec),
                .stall_src (stall_src[i]),
                .fwd_sel   (fwd_sel[src_lsb(i, SEL_W) +: SEL_W])
            );
        end
    endgenerate

    assign stall         = |stall_src;
    assign bus.stall     = stall;
    assign bus.stall_src = stall_src;
    assign bus.fwd_sel   = fwd_sel;
    assign bus.stall_cnt = stall_cnt_q;

    // Next state: load stage 1 (or a bubble), shift older writers unconditionally, count stalls.
    always_comb begin
        load = !(stall || bus.flush || !bus.d_valid || (bus.d_r_new == '0));

        stg_valid_d[0] = load;
        stg_rnew_d[0]  = load ? bus.d_r_new : '0;
        stg_tnew_d[0]  = load ? sat_dec(bus.d_t_new) : '0;

        for (int k = 1; k < NSTAGE; k++) begin
            stg_valid_d[k] = stg_valid_q[k-1];
            stg_rnew_d[k]  = stg_rnew_q[k-1];
            stg_tnew_d[k]  = sat_dec(stg_tnew_q[k-1]);
        end

        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // State registers; reset clears the pipe so stall drops without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_valid_q <= '0;
            stg_rnew_q  <= '0;
            stg_tnew_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_rnew_q  <= stg_rnew_d;
            stg_tnew_q  <= stg_tnew_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised Tuse/Tnew hazard unit for the pipelined MIPS core.
- Consumes the per-instruction decode-stage descriptors (r_new, t_new, r_use[], t_use[]) and tracks in-flight writers through NSTAGE post-decode stages (default E/M/W).
- Drives the D-stage stall, the per-source forwarding selects and a saturating stall-cycle counter.
- Supersedes fixed-two-source, fixed-depth hazard logic.

Parameters:
- NSTAGE, 3, post-decode stages tracked (stage 1 = E, stage NSTAGE = last write stage).
- NSRC, 2, source operands per instruction.
- REG_AW, 5, register address width; address 0 is hardwired zero.
- T_W, 2, width of every t_new/t_use field.
- CNT_W, 32, stall counter width.
- SEL_W (localparam), clog2(NSTAGE+1), forwarding-select width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  D stage holds a real instruction
- d_r_new  in  REG_AW  destination of D instruction (0 = none)
- d_t_new  in  T_W  cycles from D until result exists
- d_r_use  in  NSRC*REG_AW  packed source registers; source i at [i*REG_AW +: REG_AW]
- d_t_use  in  NSRC*T_W  packed cycles from D until source i is consumed
- flush  in  1  kill the instruction entering stage 1 this cycle
- stall  out  1  hold PC/F/D, insert bubble into stage 1
- stall_src  out  NSRC  per-source stall cause
- fwd_sel  out  NSRC*SEL_W  per source: 0 = register file, k = forward from stage k
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- State: NSTAGE entries {valid, r_new, t_new}.
- Reset (async): all valid=0, r_new=0, t_new=0, stall_cnt=0. After reset, stall=0, stall_src=0, fwd_sel=0.
- Stage 1 load, every clk edge:
  - If stall | flush | !d_valid | d_r_new==0: load a bubble (valid=0).
  - Otherwise load {1, d_r_new, sat_dec(d_t_new)}, where sat_dec(x) = (x==0) ? 0 : x-1.
- Advance: entry[k+1] <= {entry[k].valid, entry[k].r_new, sat_dec(entry[k].t_new)} for k = 1..NSTAGE-1. Entry NSTAGE retires.
- Advance is unconditional. A stall only affects stage-1 loading; writers already past D never stop.
- Match (per source i, combinational): ignore the source when r_use_i==0. Otherwise pick the lowest k (youngest) with entry[k].valid && entry[k].r_new==r_use_i. Older matches are shadowed.
- stall_src[i] = match exists && entry[k].t_new > t_use_i (unsigned compare).
- stall = OR of stall_src.
- fwd_sel_i = k if a match exists and entry[k].t_new==0, else 0.
  - fwd_sel is still driven when stall=1; the consumer ignores it.
  - A match with 0 < t_new <= t_use_i gives fwd_sel=0 and no stall; the downstream stage forwards later.
- stall_cnt increments on each clk where stall=1 and saturates at all-ones (no wrap).
- Simultaneous stall & flush: bubble, counted as a stall cycle.
- Same register in both sources: each source is evaluated independently; identical results.
- Reset mid-stall: entries clear immediately and stall drops asynchronously.
- All outputs except stall_cnt are combinational from state and D inputs; zero-cycle latency.

Decomposition:
- Shared package/header (alongside the instruction-code defines):
  - default T_W and REG_AW
  - descriptor field offsets for the packed d_r_use/d_t_use buses
  - SEL_W = 0 encoding for "register file"
- One sub-module: hazard_match. It takes one source (r_use, t_use) plus the flattened stage vector and returns {stall_src, fwd_sel}. It is instantiated NSRC times via generate.
- The sat_dec step is a local function.

Test Plan:
- lw $1 then addu $3,$1,$2 (d_t_new=3 then t_use=1): 1 stall cycle (E t_new=2>1), stall_src=01, stall_cnt=1. Next cycle M t_new=1, no stall, fwd_sel0=0. Following cycle W t_new=0 gives fwd_sel0=3 if still in D.
- addu $1 (t_new=2) then addu $4,$1,$1: no stall. E t_new=1<=1, both fwd_sel=0 at D. One cycle later the older writer is in M with t_new=0, giving fwd_sel=2.
- Same address in stages 1 and 2 (writers of $5 back-to-back, t_new 3 and 2), then consumer with t_use=0: youngest (stage 1, t_new=2) wins, stall=1. The older stage-2 entry is ignored.
- r_use=0 against an in-flight writer with r_new=0 or the lw case: never stall, fwd_sel=0. Also a flush on the lw load cycle removes the later stall.
- Assert reset while stall=1 with entries valid: stall, stall_src and fwd_sel go to 0 before the next clk edge, and stall_cnt=0.
- Parameter sweep NSTAGE=5, NSRC=3, T_W=3: d_t_new=5 and t_use=0 stalls 4 cycles. Force stall_cnt near max with CNT_W=4: it saturates at 15.
